uart_motor_cmd: RTL and testbench
=================================

// Module: uart_motor_cmd
// PURPOSE
//  Downstream consumer of UART_Rx_fsm's byte stream (rx_data/rx_done); replaces single-byte motor control.
//  Frames 4-byte command packets, verifies checksum, and drives INA/INB of the H-bridge with 8-bit PWM.
//  Inserts dead time on direction reversal; a watchdog forces coast when the link goes silent.
// PARAMETERS
//  PWM_DIV      64        clk cycles per PWM tick (16MHz/64/255 ~= 980Hz PWM)
//  DEADTIME     1600      clk cycles both outputs low on fwd<->rev change (100us @16MHz)
//  BYTE_TO      32000     max clk cycles between bytes of one frame before parser abort (2ms)
//  WDOG_CYCLES  16000000  clk cycles with no valid frame before forced coast (1s)
// PORTS
//  clk        in   1  system clock (clk_wiz 16MHz domain)
//  rst        in   1  asynchronous reset, active-low
//  rx_data    in   8  received byte from UART_Rx_fsm, valid when rx_done=1
//  rx_done    in   1  one-cycle strobe, new byte available
//  INA        out  1  H-bridge input A
//  INB        out  1  H-bridge input B
//  frame_ok   out  1  one-cycle pulse: valid frame accepted
//  frame_err  out  1  one-cycle pulse: bad checksum, illegal cmd, or inter-byte timeout
//  wdog_trip  out  1  high while watchdog has forced coast
//  cur_dir    out  2  active direction: 0 coast, 1 fwd, 2 rev, 3 brake
//  cur_duty   out  8  active duty (0..255)
// BEHAVIOUR
//  Reset (rst=0): all outputs 0; parser IDLE; PWM counters 0; watchdog counter 0; no pending cmd.
//  Frame: [0xA5][cmd][duty][chk], chk = 0xA5 ^ cmd ^ duty; cmd legal 0x00..0x03 (=cur_dir code).
//  Parser FSM, advances only on rx_done:
//   IDLE: byte==0xA5 -> CMD; any other byte ignored, no error.
//   CMD: store cmd -> DUTY.  DUTY: store duty -> CHK.
//   CHK: chk ok and cmd<=3 -> frame_ok next cycle, IDLE; else frame_err next cycle, IDLE.
//   In CMD/DUTY/CHK, BYTE_TO cycles without rx_done -> frame_err, IDLE (timer clears on each rx_done).
//   0xA5 received in CMD/DUTY/CHK is treated as data, never as resync.
//  Apply (same edge as frame_ok rises):
//   no reversal: cur_dir/cur_duty load immediately; wdog_trip clears; watchdog counter clears.
//   reversal (cur_dir fwd and new rev, or vice versa): cur_dir<=0, duty held in pending regs,
//    DEAD counter runs DEADTIME cycles, then pending loads into cur_dir/cur_duty.
//   New valid frame during DEAD: overwrites pending; DEAD counter not restarted. If the new cmd is
//    not the opposite of the pre-reversal direction, it still waits for DEAD to finish.
//  Watchdog: counts every cycle, clears on frame_ok; at WDOG_CYCLES-1: cur_dir<=0, cur_duty<=0,
//   pending/DEAD cancelled, wdog_trip<=1; counter saturates until next frame_ok.
//  PWM: prescaler 0..PWM_DIV-1; tick at wrap; pwm_cnt 0..254, wraps 254->0 on tick.
//   pwm = (pwm_cnt < duty_eff); duty 0 -> always low, 255 -> always high.
//   duty_eff <= cur_duty only at pwm_cnt wrap (glitch-free); counter never reset by commands.
//  Output map (registered, 1 cycle after pwm/cur_dir): coast 00, fwd INA=pwm INB=0,
//   rev INA=0 INB=pwm, brake 11. INA&INB=1 only in brake; never during fwd/rev transitions.
//  rst mid-frame or mid-DEAD: immediate 00 outputs, full state clear.
// TESTING (sim params: PWM_DIV=2, DEADTIME=20, BYTE_TO=50, WDOG_CYCLES=2000)
//  A5 01 80 24 -> frame_ok 1 pulse, cur_dir=1, cur_duty=0x80; INA high 128 of 255 ticks, INB=0.
//  fwd running, send A5 02 40 E7 -> INA=INB=0 for 20 clks, then cur_dir=2, INB PWM 64/255.
//  A5 01 80 25 (bad chk) -> frame_err pulse; cur_dir/cur_duty unchanged. Cmd 0x05 -> frame_err.
//  A5 01, then silence 60 clks -> frame_err; then full valid frame accepted normally.
//  Duty FF / 00 -> INA constant 1 / constant 0; A5 03 00 A6 -> INA=INB=1.
//  No frames for 2000 clks -> wdog_trip=1, INA=INB=0; next valid frame clears wdog_trip.

Source files
------------

// File: rtl/uart_motor_cmd.sv
// Framed UART motor command decoder: parses 4-byte checksummed packets and drives
// an H-bridge (INA/INB) with 8-bit PWM, reversal dead time and a link watchdog.
module uart_motor_cmd #(
    parameter int PWM_DIV     = 64,
    parameter int DEADTIME    = 1600,
    parameter int BYTE_TO     = 32000,
    parameter int WDOG_CYCLES = 16000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       INA,
    output logic       INB,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       wdog_trip,
    output logic [1:0] cur_dir,
    output logic [7:0] cur_duty
);

    localparam logic [7:0] SYNC     = 8'hA5;
    localparam logic [7:0] PWM_LAST = 8'd254;

    localparam int PRE_W = $clog2(PWM_DIV + 1);
    localparam int DT_W  = $clog2(DEADTIME + 1);
    localparam int TO_W  = $clog2(BYTE_TO + 1);
    localparam int WD_W  = $clog2(WDOG_CYCLES + 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);
    localparam logic [DT_W-1:0]  DT_LAST  = DT_W'(DEADTIME - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BYTE_TO - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WDOG_CYCLES - 1);

    typedef enum logic [1:0] {
        DIR_COAST = 2'd0,
        DIR_FWD   = 2'd1,
        DIR_REV   = 2'd2,
        DIR_BRAKE = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        P_IDLE,
        P_CMD,
        P_DUTY,
        P_CHK
    } pstate_e;

    // ------------------------------------------------------------------
    // Frame parser
    // ------------------------------------------------------------------
    pstate_e          state, state_nxt;
    logic [7:0]       cmd_q, duty_q;
    logic [TO_W-1:0]  to_cnt;
    logic             byte_timeout;
    logic             chk_good;
    logic             accept, reject;

    assign byte_timeout = (state != P_IDLE) && !rx_done && (to_cnt == TO_LAST);
    assign chk_good     = (rx_data == (SYNC ^ cmd_q ^ duty_q)) && (cmd_q[7:2] == 6'd0);

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        if (byte_timeout) begin
            state_nxt = P_IDLE;
            reject    = 1'b1;
        end else if (rx_done) begin
            case (state)
                P_IDLE: if (rx_data == SYNC) state_nxt = P_CMD;
                P_CMD:  state_nxt = P_DUTY;
                P_DUTY: state_nxt = P_CHK;
                P_CHK: begin
                    state_nxt = P_IDLE;
                    accept    = chk_good;
                    reject    = !chk_good;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= P_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q     <= '0;
            duty_q    <= '0;
            to_cnt    <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_ok  <= accept;
            frame_err <= reject;
            if (rx_done && state == P_CMD)  cmd_q  <= rx_data;
            if (rx_done && state == P_DUTY) duty_q <= rx_data;
            if (state == P_IDLE || rx_done) to_cnt <= '0;
            else if (to_cnt != TO_LAST)     to_cnt <= to_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Command apply, reversal dead time and watchdog
    // ------------------------------------------------------------------
    logic [1:0]      new_dir;
    logic [7:0]      new_duty;
    logic            reversal;
    logic            wdog_fire;
    logic            dead_active;
    logic [DT_W-1:0] dead_cnt;
    logic [1:0]      pend_dir;
    logic [7:0]      pend_duty;
    logic [WD_W-1:0] wdog_cnt;

    assign new_dir   = cmd_q[1:0];
    assign new_duty  = duty_q;
    assign reversal  = (cur_dir == DIR_FWD && new_dir == DIR_REV) ||
                       (cur_dir == DIR_REV && new_dir == DIR_FWD);
    assign wdog_fire = !accept && (wdog_cnt == WD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_dir     <= DIR_COAST;
            cur_duty    <= '0;
            pend_dir    <= DIR_COAST;
            pend_duty   <= '0;
            dead_active <= 1'b0;
            dead_cnt    <= '0;
            wdog_cnt    <= '0;
            wdog_trip   <= 1'b0;
        end else begin
            if (accept)                   wdog_cnt <= '0;
            else if (wdog_cnt != WD_LAST) wdog_cnt <= wdog_cnt + 1'b1;

            if (accept)         wdog_trip <= 1'b0;
            else if (wdog_fire) wdog_trip <= 1'b1;

            if (wdog_fire) begin
                cur_dir     <= DIR_COAST;
                cur_duty    <= '0;
                dead_active <= 1'b0;
                dead_cnt    <= '0;
            end else if (dead_active) begin
                // A frame arriving mid-dead-time only replaces the pending command.
                if (accept) begin
                    pend_dir  <= new_dir;
                    pend_duty <= new_duty;
                end
                if (dead_cnt == DT_LAST) begin
                    dead_active <= 1'b0;
                    dead_cnt    <= '0;
                    cur_dir     <= accept ? new_dir  : pend_dir;
                    cur_duty    <= accept ? new_duty : pend_duty;
                end else begin
                    dead_cnt <= dead_cnt + 1'b1;
                end
            end else if (accept) begin
                if (reversal) begin
                    cur_dir     <= DIR_COAST;
                    pend_dir    <= new_dir;
                    pend_duty   <= new_duty;
                    dead_active <= 1'b1;
                    dead_cnt    <= '0;
                end else begin
                    cur_dir  <= new_dir;
                    cur_duty <= new_duty;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // PWM generator and registered bridge outputs
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] presc;
    logic [7:0]       pwm_cnt;
    logic [7:0]       duty_eff;
    logic             tick;
    logic             pwm;

    assign tick = (presc == PRE_LAST);
    assign pwm  = (pwm_cnt < duty_eff);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc    <= '0;
            pwm_cnt  <= '0;
            duty_eff <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                // Duty only changes at period boundary so no runt pulses appear.
                if (pwm_cnt == PWM_LAST) begin
                    pwm_cnt  <= '0;
                    duty_eff <= cur_duty;
                end else begin
                    pwm_cnt <= pwm_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            INA <= 1'b0;
            INB <= 1'b0;
        end else begin
            case (cur_dir)
                DIR_FWD:   begin INA <= pwm;  INB <= 1'b0; end
                DIR_REV:   begin INA <= 1'b0; INB <= pwm;  end
                DIR_BRAKE: begin INA <= 1'b1; INB <= 1'b1; end
                default:   begin INA <= 1'b0; INB <= 1'b0; end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_motor_cmd.sv
// Bench for uart_motor_cmd: directed frames, a scoreboard of expected frame pulses
// checked by an independent monitor, plus PWM / dead-time / watchdog measurements.
`timescale 1ns/1ps
module tb_uart_motor_cmd;

    localparam int PWM_DIV     = 2;
    localparam int DEADTIME    = 20;
    localparam int BYTE_TO     = 50;
    localparam int WDOG_CYCLES = 2000;
    localparam int PERIOD      = 255 * PWM_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       INA, INB, frame_ok, frame_err, wdog_trip;
    logic [1:0] cur_dir;
    logic [7:0] cur_duty;

    always #5 clk = ~clk;

    uart_motor_cmd #(
        .PWM_DIV    (PWM_DIV),
        .DEADTIME   (DEADTIME),
        .BYTE_TO    (BYTE_TO),
        .WDOG_CYCLES(WDOG_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .INA      (INA),
        .INB      (INB),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .wdog_trip(wdog_trip),
        .cur_dir  (cur_dir),
        .cur_duty (cur_duty)
    );

    typedef struct {
        bit         ok;
        bit         chk_state;
        logic [1:0] dir;
        logic [7:0] duty;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every frame pulse must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && (frame_ok || frame_err)) begin
                if (exp_q.size() == 0) begin
                    check("frame pulse with empty scoreboard", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_ok", frame_ok, e.ok);
                    check("frame_err", frame_err, !e.ok);
                    if (e.chk_state) begin
                        check("cur_dir at frame", cur_dir, e.dir);
                        check("cur_duty at frame", cur_duty, e.duty);
                    end
                end
            end
        end
    end

    initial begin
        #600us;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k,
                              input bit ok, input bit chk_state,
                              input logic [1:0] dir, input logic [7:0] duty);
        exp_t e;
        e.ok = ok; e.chk_state = chk_state; e.dir = dir; e.duty = duty;
        exp_q.push_back(e);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(d);
        send_byte(k);
    endtask

    // Counts high cycles of INA (sel=0) or INB (sel=1) over one full PWM period.
    task automatic count_high(input bit sel, output int hi);
        hi = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            if ((sel ? INB : INA) === 1'b1) hi++;
        end
    endtask

    initial begin
        int hi, dead, viol, t0;

        // Reset state
        wait_clks(3);
        check("rst INA", INA, 0);
        check("rst INB", INB, 0);
        check("rst frame_ok", frame_ok, 0);
        check("rst frame_err", frame_err, 0);
        check("rst wdog_trip", wdog_trip, 0);
        check("rst cur_dir", cur_dir, 0);
        check("rst cur_duty", cur_duty, 0);
        rst = 1'b1;
        wait_clks(2);

        // Junk in IDLE is ignored, then forward at 128/255
        send_byte(8'h00);
        send_byte(8'h5A);
        send_frame(8'h01, 8'h80, 8'h24, 1, 1, 2'd1, 8'h80);
        wait_clks(600);
        count_high(0, hi); check("fwd 0x80 INA high cycles", hi, 256);
        count_high(1, hi); check("fwd 0x80 INB high cycles", hi, 0);

        // Reversal fwd -> rev with dead time
        send_frame(8'h02, 8'h40, 8'hE7, 1, 0, 2'd0, 8'h00);
        dead = 0;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            if (cur_dir == 2'd2) break;
            if (cur_dir == 2'd0) begin
                dead++;
                if (i > 0 && (INA || INB)) viol++;
            end
            @(negedge clk);
        end
        check("dead time cycles", dead, DEADTIME);
        check("outputs active during dead time", viol, 0);
        check("rev cur_dir", cur_dir, 2);
        check("rev cur_duty", cur_duty, 8'h40);
        wait_clks(600);
        count_high(1, hi); check("rev 0x40 INB high cycles", hi, 128);
        count_high(0, hi); check("rev 0x40 INA high cycles", hi, 0);

        // Rejected frames: bad checksum, illegal cmd, inter-byte timeout
        send_frame(8'h01, 8'h80, 8'h25, 0, 1, 2'd2, 8'h40);
        send_frame(8'h05, 8'h80, 8'h20, 0, 1, 2'd2, 8'h40);
        begin
            exp_t e;
            e.ok = 0; e.chk_state = 1; e.dir = 2'd2; e.duty = 8'h40;
            exp_q.push_back(e);
        end
        send_byte(8'hA5);
        send_byte(8'h01);
        wait_clks(60);
        check("state kept after rejects", {cur_dir, cur_duty}, {2'd2, 8'h40});

        // 0xA5 inside a frame is data, not a resync
        send_frame(8'h02, 8'hA5, 8'h02, 1, 1, 2'd2, 8'hA5);

        // Brake
        send_frame(8'h03, 8'h00, 8'hA6, 1, 1, 2'd3, 8'h00);
        wait_clks(5);
        check("brake INA", INA, 1);
        check("brake INB", INB, 1);

        // Duty extremes in forward
        send_frame(8'h01, 8'h00, 8'hA4, 1, 1, 2'd1, 8'h00);
        wait_clks(600);
        count_high(0, hi); check("duty 0x00 INA high cycles", hi, 0);
        send_frame(8'h01, 8'hFF, 8'h5B, 1, 1, 2'd1, 8'hFF);
        t0 = cyc;
        wait_clks(600);
        count_high(0, hi); check("duty 0xFF INA high cycles", hi, PERIOD);

        // Watchdog
        for (int i = 0; i < 3000 && !wdog_trip; i++) @(negedge clk);
        check("watchdog trip latency", cyc - t0, WDOG_CYCLES);
        check("wdog_trip set", wdog_trip, 1);
        check("wdog cur_dir", cur_dir, 0);
        check("wdog cur_duty", cur_duty, 0);
        wait_clks(2);
        check("wdog INA", INA, 0);
        check("wdog INB", INB, 0);

        send_frame(8'h02, 8'h40, 8'hE7, 1, 1, 2'd2, 8'h40);
        check("wdog_trip cleared by frame", wdog_trip, 0);

        // Reset in the middle of a reversal dead time
        send_frame(8'h01, 8'h80, 8'h24, 1, 0, 2'd0, 8'h00);
        wait_clks(5);
        check("scoreboard drained before reset", exp_q.size(), 0);
        rst = 1'b0;
        #1;
        check("mid-dead rst INA/INB", {INA, INB}, 2'b00);
        check("mid-dead rst cur_dir", cur_dir, 0);
        wait_clks(3);
        rst = 1'b1;
        wait_clks(30);
        check("no pending after reset", cur_dir, 0);
        check("outputs idle after reset", {INA, INB}, 2'b00);

        wait_clks(5);
        check("scoreboard empty at end", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
